// File: rtl/gpio_pwm_meas_if.sv
// Port bundle for gpio_pwm_meas: control, pin input and published measurement.
// master drives control and pin; slave is the measurement block.
interface gpio_pwm_meas_if;
    logic        meas_en;
    logic [2:0]  meas_prescale;
    logic        pin_in;
    logic [31:0] meas_d;
    logic        meas_vld;
    logic        meas_busy;
    logic        meas_stuck;

    modport master (
        output meas_en, meas_prescale, pin_in,
        input  meas_d, meas_vld, meas_busy, meas_stuck
    );

    modport slave (
        input  meas_en, meas_prescale, pin_in,
        output meas_d, meas_vld, meas_busy, meas_stuck
    );
endinterface

// File: rtl/gpio_pwm_meas.sv
// GPIO PWM measurement: high/low time of one pin in prescaler units, packed like the PWM config.
// Optional glitch filter after the synchronizer: define PWM_MEAS_GLITCH_FILTER_EN.
module gpio_pwm_meas #(
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned SYNC_STAGES = 2
`ifdef PWM_MEAS_GLITCH_FILTER_EN
    ,
    parameter int unsigned FILT_LEN    = 3
`endif
) (
    input logic             clk_cap,
    input logic             reset,
    gpio_pwm_meas_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StWaitRise, StMeasHi, StMeasLo} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl, prev_q, rise, fall, start_hi, tick;
    logic [6:0]             presc_q, presc_d, presc_cur, presc_mask;
    logic [2:0]             p_used_q, p_used_d, p_eff;
    logic [CNT_W-1:0]       hi_q, hi_d, lo_q, lo_d;
    logic                   ovf_hi_q, ovf_hi_d, ovf_lo_q, ovf_lo_d;
    logic [31:0]            meas_d_q, meas_d_d;
    logic                   meas_vld_q, meas_vld_d;

    always_ff @(posedge clk_cap or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pin_in};
    end

`ifdef PWM_MEAS_GLITCH_FILTER_EN
    localparam int unsigned FiltW = $clog2(FILT_LEN + 1);
    logic             filt_q, filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;

    // Level flips only after FILT_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (filt_cnt_q == FiltW'(FILT_LEN - 1)) filt_d = sync_q[SYNC_STAGES-1];
            else                                    filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_cap or posedge reset) begin
        if (reset) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    assign rise     = lvl & ~prev_q;
    assign fall     = ~lvl & prev_q;
    assign start_hi = rise & bus.meas_en & ((state_q == StWaitRise) | (state_q == StMeasLo));

    // The edge cycle is index 0 of the new phase, so a new prescale applies to it already.
    assign p_eff      = start_hi ? bus.meas_prescale : p_used_q;
    assign presc_mask = ~(7'h7F << p_eff);
    assign presc_cur  = (rise | fall) ? 7'd0 : presc_q;
    assign tick       = (presc_cur == presc_mask);
    assign presc_d    = (tick || state_q == StIdle) ? 7'd0 : presc_cur + 7'd1;

    // State register
    always_ff @(posedge clk_cap or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!bus.meas_en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:     state_d = StWaitRise;
                StWaitRise: if (rise) state_d = StMeasHi;
                StMeasHi:   if (fall) state_d = StMeasLo;
                StMeasLo:   if (rise) state_d = StMeasHi;
                default:    state_d = StIdle;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.meas_busy  = (state_q != StIdle);
        bus.meas_stuck = ((state_q == StMeasHi) && (hi_q == CntMax)) ||
                         ((state_q == StMeasLo) && (lo_q == CntMax));
        bus.meas_d     = meas_d_q;
        bus.meas_vld   = meas_vld_q;
    end

    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        ovf_hi_d   = ovf_hi_q;
        ovf_lo_d   = ovf_lo_q;
        p_used_d   = p_used_q;
        meas_d_d   = meas_d_q;
        meas_vld_d = 1'b0;
        if (!bus.meas_en || state_q == StIdle) begin
            hi_d     = '0;
            lo_d     = '0;
            ovf_hi_d = 1'b0;
            ovf_lo_d = 1'b0;
        end else if (start_hi) begin
            if (state_q == StMeasLo) begin
                meas_d_d   = {hi_q, lo_q, 1'b0, p_used_q, 1'b0, ovf_lo_q, ovf_hi_q, 1'b1};
                meas_vld_d = 1'b1;
            end
            hi_d     = {{(CNT_W-1){1'b0}}, tick};
            ovf_hi_d = 1'b0;
            p_used_d = bus.meas_prescale;
        end else if (state_q == StMeasHi) begin
            if (fall) begin
                lo_d     = {{(CNT_W-1){1'b0}}, tick};
                ovf_lo_d = 1'b0;
            end else if (tick) begin
                if (hi_q == CntMax) ovf_hi_d = 1'b1;
                else                hi_d     = hi_q + 1'b1;
            end
        end else if (state_q == StMeasLo && tick) begin
            if (lo_q == CntMax) ovf_lo_d = 1'b1;
            else                lo_d     = lo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_cap or posedge reset) begin
        if (reset) begin
            prev_q     <= 1'b0;
            presc_q    <= '0;
            p_used_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            ovf_hi_q   <= 1'b0;
            ovf_lo_q   <= 1'b0;
            meas_d_q   <= '0;
            meas_vld_q <= 1'b0;
        end else begin
            prev_q     <= lvl;
            presc_q    <= presc_d;
            p_used_q   <= p_used_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            ovf_hi_q   <= ovf_hi_d;
            ovf_lo_q   <= ovf_lo_d;
            meas_d_q   <= meas_d_d;
            meas_vld_q <= meas_vld_d;
        end
    end
endmodule

// File: tb/tb_gpio_pwm_meas.sv
// Directed bench for gpio_pwm_meas: period publish, prescale, saturation, disable,
// glitch handling and asynchronous reset.
module tb_gpio_pwm_meas;
    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;
    int   vld_cnt = 0;
    int   base;
    logic [31:0] last_d = '0;

`ifdef PWM_MEAS_GLITCH_FILTER_EN
    localparam int ExtraLat = 3;
`else
    localparam int ExtraLat = 0;
`endif

    gpio_pwm_meas_if bus ();

    gpio_pwm_meas dut (
        .clk_cap (clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.meas_vld === 1'b1) begin
            vld_cnt = vld_cnt + 1;
            last_d  = bus.meas_d;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive pin level v for n rising clock edges; returns 1 time unit after the last edge.
    task automatic hold(input logic v, input int n);
        bus.pin_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.meas_en       = 1'b0;
        bus.meas_prescale = 3'd0;
        bus.pin_in        = 1'b0;
        #2;
        check("rst_d", bus.meas_d, 32'h0);
        check("rst_vld", {31'b0, bus.meas_vld}, 32'h0);
        check("rst_busy", {31'b0, bus.meas_busy}, 32'h0);
        check("rst_stuck", {31'b0, bus.meas_stuck}, 32'h0);
        hold(1'b0, 3);
        reset       = 1'b0;
        bus.meas_en = 1'b1;

        // 10 hi / 20 lo at p=0
        hold(1'b0, 5);
        repeat (3) begin
            hold(1'b1, 10);
            hold(1'b0, 20);
        end
        hold(1'b1, 10);
        hold(1'b0, 5);
        check("p0_count", 32'(vld_cnt), 32'd3);
        check("p0_d", last_d, 32'h00A01401);
        check("p0_busy", {31'b0, bus.meas_busy}, 32'h1);

        // Prescale change mid-period applies from the next rise
        bus.meas_prescale = 3'd2;
        hold(1'b0, 15);
        hold(1'b1, 40);
        check("p2_prev_d", last_d, 32'h00A01401);
        hold(1'b0, 13);
        hold(1'b1, 10);
        hold(1'b0, 5);
        check("p2_count", 32'(vld_cnt), 32'd5);
        check("p2_d", last_d, 32'h00A00321);

        // Disable mid MEAS_LO
        bus.meas_en       = 1'b0;
        bus.meas_prescale = 3'd0;
        hold(1'b0, 1);
        @(negedge clk);
        check("dis_busy", {31'b0, bus.meas_busy}, 32'h0);
        hold(1'b1, 10);
        hold(1'b0, 10);
        hold(1'b1, 8);
        check("dis_count", 32'(vld_cnt), 32'd5);
        check("dis_d_hold", bus.meas_d, 32'h00A00321);
        bus.meas_en = 1'b1;
        hold(1'b1, 8);
        hold(1'b0, 12);
        hold(1'b1, 7);
        hold(1'b0, 9);
        check("reen_no_vld", 32'(vld_cnt), 32'd5);
        hold(1'b1, 10);
        hold(1'b0, 6);
        check("reen_count", 32'(vld_cnt), 32'd6);
        check("reen_d", last_d, 32'h00700901);

        // Stuck high, saturating hi counter
        hold(1'b1, 4096 + ExtraLat);
        @(negedge clk);
        check("stuck_before", {31'b0, bus.meas_stuck}, 32'h0);
        hold(1'b1, 1);
        @(negedge clk);
        check("stuck_set", {31'b0, bus.meas_stuck}, 32'h1);
        hold(1'b1, 5000 - 4097 - ExtraLat);
        check("stuck_hold", {31'b0, bus.meas_stuck}, 32'h1);
        hold(1'b0, 4);
        hold(1'b1, 10);
        check("sat_d", last_d, 32'hFFF00403);
        check("stuck_clear", {31'b0, bus.meas_stuck}, 32'h0);

        // 2-cycle low glitch inside 30-cycle high
        hold(1'b0, 20);
        base = vld_cnt;
        hold(1'b1, 14);
        hold(1'b0, 2);
        hold(1'b1, 14);
`ifdef PWM_MEAS_GLITCH_FILTER_EN
        check("glitch_mid_d", last_d, 32'h00A01401);
`else
        check("glitch_mid_d", last_d, 32'h00E00201);
`endif
        hold(1'b0, 20);
        hold(1'b1, 10);
`ifdef PWM_MEAS_GLITCH_FILTER_EN
        check("glitch_count", 32'(vld_cnt - base), 32'd2);
        check("glitch_d", last_d, 32'h01E01401);
`else
        check("glitch_count", 32'(vld_cnt - base), 32'd3);
        check("glitch_d", last_d, 32'h00E01401);
`endif

        // Asynchronous reset during MEAS_HI
        reset = 1'b1;
        #1;
        check("arst_d", bus.meas_d, 32'h0);
        check("arst_vld", {31'b0, bus.meas_vld}, 32'h0);
        check("arst_busy", {31'b0, bus.meas_busy}, 32'h0);
        check("arst_stuck", {31'b0, bus.meas_stuck}, 32'h0);
        hold(1'b0, 2);
        reset = 1'b0;
        base  = vld_cnt;
        hold(1'b0, 5);
        repeat (2) begin
            hold(1'b1, 10);
            hold(1'b0, 20);
        end
        hold(1'b1, 10);
        check("post_rst_count", 32'(vld_cnt - base), 32'd2);
        check("post_rst_d", last_d, 32'h00A01401);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
